pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit for the datapath. It replaces the fixed 8-bit combinational adder with a WIDTH-bit adder whose carry chain is split across STAGES register stages. It carries valid/ready handshakes on both sides and reports carry, signed overflow and zero flags for the ALU and branch logic.

## Interface

**Parameters**
- WIDTH, default 32: operand and result width. Must be ≥ 2 and a multiple of STAGES.
- STAGES, default 4: pipeline depth; each stage adds one slice of SLICE = WIDTH/STAGES bits. STAGES ≥ 1.

**Ports**
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  unit can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A − B, 0 = A + B.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0 (after clamping, if enabled).

## Operation

- **Effective operation:**
  - B' = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Full result = A + B' + c0, computed modulo 2^WIDTH.
- **Stage i (1..STAGES):**
  - Adds slice i−1 (bits [i·SLICE−1 : (i−1)·SLICE]) of A and B', plus the carry registered by stage i−1 (c0 for stage 1).
  - Registers that slice result and its carry-out.
  - Slices not yet added, and lower result slices already computed, travel along as registered state.
- **Final stage flags:**
  - cout = carry out of bit WIDTH−1.
  - ovf = (A[MSB] == B'[MSB]) && (raw sum[MSB] != A[MSB]).
  - zero is evaluated on the final sum.
- **Pipeline control:**
  - Each stage holds a valid bit.
  - Global stall: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts forward one position, and stage 1 loads in_valid && in_ready.
  - When adv=0, all stages hold.
  - No reordering, no drops, no duplication.
- **Reset:**
  - All valid bits clear, so out_valid = 0.
  - sum, cout, ovf and zero all = 0.
  - In-flight operations are discarded.
  - in_ready = 1 in the cycle after reset deasserts.

## Timing

- **Accept:** occurs on rising edge k when in_valid && in_ready.
- **Latency:** the result drives out_valid=1 after edge k+STAGES−1.
  - STAGES=1: the result is registered on the accepting edge.
- **Throughput:** one operation per cycle while out_ready=1.
- **Outputs:** sum, cout, ovf and zero are registered and stable while out_valid && !out_ready.
- **Consume:** the result is consumed on the edge where out_valid && out_ready. The next result (if any) appears the same edge.
- **Simultaneous consume and accept:** both occur on the same edge with out_ready=1 and a full pipeline; in_ready stays 1.
- **rst wins:** rst overrides handshakes on the same edge; a transaction presented during rst is not accepted.
- **Wrap-around:** sum wraps modulo 2^WIDTH (unless saturation is enabled).

## Configuration

- **ADDER_SATURATE_EN defined:**
  - On ovf=1, sum is clamped in the final stage: positive overflow → 0x7F…F, negative overflow → 0x80…0.
  - ovf and cout still report the unclamped result.
  - zero reflects the clamped sum.
  - Latency is unchanged.
- **ADDER_SATURATE_EN undefined:**
  - sum wraps; no clamping logic is generated.

## Test plan

Configuration for all scenarios: WIDTH=8, STAGES=2, out_ready=1 unless stated.

1. **Add overflow.** a=255, b=1, sub=0, cin=0 accepted at edge k → after edge k+1: sum=0, cout=1, ovf=0, zero=1, out_valid=1 for one cycle.
2. **Signed overflow.** a=127, b=1, add → wrap build: sum=0x80, ovf=1, cout=0. Saturate build: sum=0x7F, ovf=1.
3. **Subtract.**
   - a=10, b=20, sub=1 → sum=0xF6, cout=0, ovf=0.
   - a=20, b=10, sub=1, cin=0 → sum=10, cout=1.
   - Add with carry: a=10, b=20, sub=0, cin=1 → sum=31.
4. **Throughput.** Back-to-back pairs (10,20), (128,128), (1,1), (0,0) on edges k..k+3 → results 30, 0 (cout=1), 2, 0 (zero=1) on consecutive edges k+1..k+4, in order.
5. **Backpressure.**
   - Hold out_ready=0 for 3 cycles with a full pipeline → in_ready=0, sum/flags stable.
   - Release out_ready → no loss or duplication; one result per cycle.
6. **Reset mid-flight.** Assert rst for one cycle with 2 operations in flight → out_valid=0 and all outputs 0 after that edge; no stale result ever appears; a new operation accepted afterwards completes with latency 2.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder.
// Operand side: in_valid/in_ready with a, b, sub, cin.
// Result side: out_valid/out_ready with sum and the carry/overflow/zero flags.
// The slave modport is the adder; the master modport is whoever drives
// operands and consumes results.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with the carry chain cut into STAGES
// slices of SLICE = WIDTH/STAGES bits, one slice added per register stage.
// Reports carry-out, signed overflow and zero on the registered result.
//
// Optional build macro: ADDER_SATURATE_EN
//   defined   -> on signed overflow the final stage clamps sum to the most
//                positive / most negative value; ovf and cout still describe
//                the unclamped result and zero follows the clamped sum.
//   undefined -> sum wraps modulo 2^WIDTH and no clamp logic exists.
//
// WIDTH must be >= 2 and a multiple of STAGES; STAGES >= 1.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;
    // Number of inter-stage register sets; the final stage writes the
    // output registers instead, so a single-stage unit keeps one unused set.
    localparam int NQ    = (STAGES > 1) ? STAGES - 1 : 1;

    // Global stall: the whole pipe moves only when the output slot frees up.
    logic             adv;
    logic             load;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Per-stage inputs, index = stage number - 1.
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    // Per-stage next values. a_d carries A with the slices added so far
    // overwritten by result bits, so one vector serves as both the pending
    // operand and the partial sum.
    logic [WIDTH-1:0] a_d  [STAGES];
    logic             c_d  [STAGES];

    // Inter-stage registers.
    logic [WIDTH-1:0] a_q  [NQ];
    logic [WIDTH-1:0] b_q  [NQ];
    logic             c_q  [NQ];
    logic             v_q  [NQ];

    // Output registers.
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Final-stage combinational results.
    logic [WIDTH-1:0] raw_sum;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;
    logic             zero_d;

    assign adv          = !out_valid_q || bus.out_ready;
    assign load         = bus.in_valid && adv;
    assign bus.in_ready = adv;

    // Subtraction is A + ~B + 1, so cin is only meaningful for add.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? 1'b1 : bus.cin;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LSB = gi * SLICE;
            localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}}) << LSB;
            logic [SLICE:0] slice_sum;

            if (gi == 0) begin : g_src
                assign a_in[gi] = bus.a;
                assign b_in[gi] = b_eff;
                assign c_in[gi] = c0;
                assign v_in[gi] = load;
            end else begin : g_src
                assign a_in[gi] = a_q[gi-1];
                assign b_in[gi] = b_q[gi-1];
                assign c_in[gi] = c_q[gi-1];
                assign v_in[gi] = v_q[gi-1];
            end

            // One slice of the carry chain, with the carry from the stage below.
            assign slice_sum = {1'b0, a_in[gi][LSB +: SLICE]}
                             + {1'b0, b_in[gi][LSB +: SLICE]}
                             + {{SLICE{1'b0}}, c_in[gi]};
            assign a_d[gi]   = (a_in[gi] & ~SLICE_MASK)
                             | (WIDTH'(slice_sum[SLICE-1:0]) << LSB);
            assign c_d[gi]   = slice_sum[SLICE];
        end
    endgenerate

    // Inter-stage registers shift together on adv; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NQ; s++) begin
                v_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                c_q[s] <= 1'b0;
            end
        end else if (adv) begin
            for (int s = 0; s < STAGES - 1; s++) begin
                v_q[s] <= v_in[s];
                a_q[s] <= a_d[s];
                b_q[s] <= b_in[s];
                c_q[s] <= c_d[s];
            end
        end
    end

    // The top slice is still untouched on entry to the final stage, so the
    // operand sign bits are available there for the overflow test.
    assign raw_sum = a_d[LAST];
    assign a_msb   = a_in[LAST][MSB];
    assign b_msb   = b_in[LAST][MSB];
    assign ovf_d   = (a_msb == b_msb) && (raw_sum[MSB] != a_msb);

`ifdef ADDER_SATURATE_EN
    // Overflow only happens with like-signed operands, so A's sign tells
    // which rail to clamp to.
    assign sum_d = !ovf_d ? raw_sum
                 : a_msb  ? {1'b1, {(WIDTH-1){1'b0}}}
                 :          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum_d = raw_sum;
`endif

    assign zero_d = (sum_d == '0);

    // Output stage: result and flags held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_in[LAST];
            if (v_in[LAST]) begin
                sum_q  <= sum_d;
                cout_q <= c_d[LAST];
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8, STAGES=2.
// The driver pushes hand-computed results when an operand set is accepted;
// the monitor pops and compares whenever a result is consumed.
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

`ifdef ADDER_SATURATE_EN
    localparam logic [7:0] S_POS_OVF = 8'h7F;
    localparam logic [7:0] S_NEG_OVF = 8'h80;
    localparam logic       Z_NEG_OVF = 1'b0;
`else
    localparam logic [7:0] S_POS_OVF = 8'h80;
    localparam logic [7:0] S_NEG_OVF_128 = 8'h00;
    localparam logic [7:0] S_NEG_OVF = 8'h7F;
    localparam logic       Z_NEG_OVF = 1'b1;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   sent    = 0;
    int   results = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                        input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        int n = 0;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout a=%0h b=%0h in_ready=%0b required=1", a, b, bus.in_ready);
        end else begin
            sb_q.push_back('{a: a, b: b, sub: sub, sum: es, cout: ec, ovf: eo, zero: ez});
            sent++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    // Monitor: every consumed result must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin : mon
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result sum=%0h cout=%0b ovf=%0b zero=%0b required=none",
                         bus.sum, bus.cout, bus.ovf, bus.zero);
            end else begin
                e = sb_q.pop_front();
                results++;
                if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL result a=%0h b=%0h sub=%0b actual sum=%0h c=%0b v=%0b z=%0b required sum=%0h c=%0b v=%0b z=%0b",
                             e.a, e.b, e.sub, bus.sum, bus.cout, bus.ovf, bus.zero,
                             e.sum, e.cout, e.ovf, e.zero);
                end else begin
                    $display("result a=%0h b=%0h sub=%0b sum=%0h c=%0b v=%0b z=%0b ok",
                             e.a, e.b, e.sub, bus.sum, bus.cout, bus.ovf, bus.zero);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_cout", bus.cout, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_zero", bus.zero, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // 1: unsigned carry out of the MSB, latency 2, valid for one cycle.
        send(8'd255, 8'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_not_early", bus.out_valid, 0);
        @(negedge clk);
        check("t1_valid_at_latency", bus.out_valid, 1);
        @(negedge clk);
        check("t1_one_cycle", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // 2 and 3: signed overflow, subtract, carry-in handling.
        send(8'd127, 8'd1, 1'b0, 1'b0, S_POS_OVF, 1'b0, 1'b1, 1'b0);
        send(8'd10,  8'd20, 1'b1, 1'b0, 8'hF6, 1'b0, 1'b0, 1'b0);
        send(8'd20,  8'd10, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b0);
        send(8'd10,  8'd20, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0);
        send(8'd20,  8'd10, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
        send(8'h80,  8'd1,  1'b1, 1'b0, S_NEG_OVF, 1'b1, 1'b1, 1'b0);
        wait_drain();

        // 4: back-to-back throughput, one result per cycle.
        base = results;
        send(8'd10,  8'd20,  1'b0, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_SATURATE_EN
        send(8'd128, 8'd128, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, Z_NEG_OVF);
`else
        send(8'd128, 8'd128, 1'b0, 1'b0, S_NEG_OVF_128, 1'b1, 1'b1, Z_NEG_OVF);
`endif
        send(8'd1,   8'd1,   1'b0, 1'b0, 8'd2,  1'b0, 1'b0, 1'b0);
        send(8'd0,   8'd0,   1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        check("t4_throughput_count", results - base, 4);
        @(posedge clk);
        #1;

        // 5: backpressure with a full pipeline, then release.
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
        send(8'd5,  8'd5,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_in_ready_low", bus.in_ready, 0);
            check("t5_out_valid_held", bus.out_valid, 1);
            check("t5_sum_held", bus.sum, 8'h46);
            check("t5_cout_held", bus.cout, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'hF0, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        send(8'h40, 8'h40, 1'b0, 1'b0, S_POS_OVF, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // 6: reset with two operations in flight and an offer during reset.
        bus.out_ready = 1'b0;
        send(8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
        send(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h55;
        bus.b         = 8'h22;
        bus.sub       = 1'b0;
        sent          = sent - sb_q.size();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_sum", bus.sum, 0);
        check("t6_cout", bus.cout, 0);
        check("t6_ovf", bus.ovf, 0);
        check("t6_zero", bus.zero, 0);
        check("t6_in_ready", bus.in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        send(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_not_early", bus.out_valid, 0);
        @(negedge clk);
        check("t6_valid_at_latency", bus.out_valid, 1);
        @(posedge clk);
        #1;
        wait_drain();

        check("total_results", results, sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
